// File: rtl/fetch_pc_gen.sv
// Next-PC generator around the BTB: predicts from the BTB hit, queues in-flight predictions, redirects on mispredict.
// Latency: BTB lookup is combinational on pc; redirect, BTB update and redirected pc appear one cycle after resolve.
// Backpressure: fetch stalls (pc holds) while imem_ready is low or the in-flight queue is full.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int          QDEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        imem_ready,
    output logic [31:0]                 pc,
    output logic                        fetch_valid,
    output logic                        pred_taken,
    input  logic                        btb_match,
    input  logic [31:0]                 btb_target,
    input  logic                        resolve_valid,
    input  logic                        resolve_is_branch,
    input  logic                        resolve_taken,
    input  logic [31:0]                 resolve_target,
    output logic                        redirect,
    output logic                        btb_update,
    output logic [31:0]                 btb_update_addr,
    output logic [31:0]                 btb_target_addr,
    output logic [$clog2(QDEPTH):0]     q_count
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   q_pc   [QDEPTH];
    logic          q_pred [QDEPTH];
    logic [31:0]   q_tgt  [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          fire;
    logic          res_ok;
    logic          actual_taken;
    logic          target_diff;
    logic          mispredict;
    logic          need_update;
    logic [31:0]   actual_next;

    assign q_count     = count;
    assign fetch_valid = (count != CW'(QDEPTH));
    assign pred_taken  = btb_match;

    // A resolve against an empty queue is illegal and is simply dropped.
    assign fire         = fetch_valid & imem_ready;
    assign res_ok       = resolve_valid & (count != '0);
    assign actual_taken = resolve_is_branch & resolve_taken;
    assign target_diff  = (q_tgt[head] != resolve_target);
    assign mispredict   = res_ok & ((q_pred[head] != actual_taken) | (actual_taken & target_diff));
    assign need_update  = res_ok & actual_taken & (~q_pred[head] | target_diff);
    assign actual_next  = actual_taken ? resolve_target : (q_pc[head] + 32'd4);

    always_ff @(posedge clk) begin
        if (fire) begin
            q_pc[tail]   <= pc;
            q_pred[tail] <= btb_match;
            q_tgt[tail]  <= btb_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc              <= RESET_PC;
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            redirect        <= 1'b0;
            btb_update      <= 1'b0;
            btb_update_addr <= '0;
            btb_target_addr <= '0;
        end else begin
            redirect   <= mispredict;
            btb_update <= need_update;
            if (need_update) begin
                btb_update_addr <= q_pc[head];
                btb_target_addr <= resolve_target;
            end
            // A flush wins over any same-cycle push: the fetched entry is wrong-path.
            if (mispredict) begin
                pc    <= actual_next;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (fire) begin
                    pc   <= btb_match ? btb_target : (pc + 32'd4);
                    tail <= tail + 1'b1;
                end
                if (res_ok) begin
                    head <= head + 1'b1;
                end
                count <= count + CW'(fire) - CW'(res_ok);
            end
        end
    end

endmodule
